// File: rtl/ledr_share_ctrl_if.sv
// Avalon-MM slave port plus key-requester handshake for ledr_share_ctrl.
interface ledr_share_ctrl_if #(
  parameter int WIDTH = 18
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             key_req;
  logic [WIDTH-1:0] key_pattern;
  logic             key_ack;

  modport master (
    output address, chipselect, write_n, writedata, key_req, key_pattern,
    input  readdata, key_ack
  );

  modport slave (
    input  address, chipselect, write_n, writedata, key_req, key_pattern,
    output readdata, key_ack
  );
endinterface

// File: rtl/ledr_share_ctrl.sv
// Shares the red-LED bank between CPU registers and a piano-key requester with a hold timer.
// Optional blink of the CPU pattern is built when LEDR_BLINK_EN is defined.
module ledr_share_ctrl #(
  parameter int                 WIDTH        = 18,
  parameter int                 HOLD_W       = 24,
  parameter logic [HOLD_W-1:0]  HOLD_DEFAULT = HOLD_W'(1000),
  parameter int                 BLINK_DIV    = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  ledr_share_ctrl_if.slave      bus,
  output logic [WIDTH-1:0]      out_port
);

  typedef enum logic {CPU_OWN, KEY_OWN} state_t;

  state_t            state;
  logic [WIDTH-1:0]  cpu_data;
  logic [WIDTH-1:0]  key_latch;
  logic              key_en;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] cnt;
  logic [7:0]        accept_cnt;
  logic              key_ack_q;
  logic              blink_mask;
  logic              blink_rd;

  logic wr, data_wr, ctrl_wr, status_wr, hold_wr, key_off, accept, owner;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign data_wr   = wr && (bus.address == 2'd0);
  assign ctrl_wr   = wr && (bus.address == 2'd1);
  assign status_wr = wr && (bus.address == 2'd2);
  assign hold_wr   = wr && (bus.address == 2'd3);

  // A CTRL write clearing key_en on the same edge wins over a pending request.
  assign key_off = ctrl_wr & ~bus.writedata[0];
  assign accept  = key_en & bus.key_req & ~key_off;
  assign owner   = (state == KEY_OWN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CPU_OWN;
      cpu_data   <= '0;
      key_latch  <= '0;
      key_en     <= 1'b0;
      hold       <= HOLD_DEFAULT;
      cnt        <= '0;
      accept_cnt <= '0;
      key_ack_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees the pre-edge register values.
      key_ack_q <= accept;

      case (state)
        CPU_OWN: begin
          if (accept) begin
            state     <= KEY_OWN;
            key_latch <= bus.key_pattern;
            cnt       <= hold;
          end
        end
        KEY_OWN: begin
          if (key_off) begin
            state <= CPU_OWN;
            cnt   <= '0;
          end else if (accept) begin
            key_latch <= bus.key_pattern;
            cnt       <= hold;
          end else if (cnt == '0) begin
            state <= CPU_OWN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase

      if (data_wr) cpu_data <= bus.writedata[WIDTH-1:0];
      if (ctrl_wr) key_en   <= bus.writedata[0];
      if (hold_wr) hold     <= bus.writedata[HOLD_W-1:0];

      if (status_wr)
        accept_cnt <= '0;
      else if (accept && accept_cnt != 8'hFF)
        accept_cnt <= accept_cnt + 8'd1;
    end
  end

`ifdef LEDR_BLINK_EN
  localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic             blink;
  logic             phase;
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink   <= 1'b0;
      phase   <= 1'b1;
      div_cnt <= '0;
    end else begin
      if (ctrl_wr) blink <= bus.writedata[1];
      // Turning blink on restarts the pattern in its lit phase.
      if (ctrl_wr && bus.writedata[1] && !blink) begin
        phase   <= 1'b1;
        div_cnt <= '0;
      end else if (blink) begin
        if (div_cnt == DIV_W'(BLINK_DIV - 1)) begin
          div_cnt <= '0;
          phase   <= ~phase;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  assign blink_mask = ~blink | phase;
  assign blink_rd   = blink;
`else
  assign blink_mask = 1'b1;
  assign blink_rd   = 1'b0;
`endif

  assign out_port    = owner ? key_latch : (cpu_data & {WIDTH{blink_mask}});
  assign bus.key_ack = key_ack_q;

  always_comb begin
    // NOTE: default assignment first so no path leaves readdata unassigned (no latch).
    bus.readdata = '0;
    case (bus.address)
      2'd0: bus.readdata = 32'(cpu_data);
      2'd1: bus.readdata = {30'd0, blink_rd, key_en};
      2'd2: bus.readdata = {16'd0, accept_cnt, 6'd0, bus.key_req, owner};
      2'd3: bus.readdata = 32'(hold);
    endcase
  end

  // Write-data bits above the widest register are intentionally ignored.
  logic unused_wd;
  assign unused_wd = ^bus.writedata[31:HOLD_W];

endmodule

// File: tb/tb_ledr_share_ctrl.sv
// Randomized scoreboard bench for ledr_share_ctrl against a cycle-indexed ownership model.
module tb_ledr_share_ctrl;
  localparam int WIDTH = 18;
  localparam int BD    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] out_port;

  ledr_share_ctrl_if #(.WIDTH(WIDTH)) bus();

  ledr_share_ctrl #(.WIDTH(WIDTH), .BLINK_DIV(BD)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             ack;
    logic [31:0]      rd;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Staged stimulus for the next cycle
  logic [1:0]       s_addr = 2'd0;
  logic             s_cs   = 1'b0;
  logic             s_wn   = 1'b1;
  logic [31:0]      s_wd   = '0;
  logic             s_req  = 1'b0;
  logic [WIDTH-1:0] s_pat  = '0;
  logic             s_rst  = 1'b1;

  // Reference model: ownership is "current cycle index is below key_until".
  int               n = 0;
  int               key_until;
  int               blink_start;
  logic [WIDTH-1:0] m_cpu, m_latch;
  logic             m_key_en, m_blink, m_ack;
  logic [23:0]      m_hold;
  int               m_count;

  task automatic model_reset();
    key_until   = 0;
    blink_start = 0;
    m_cpu       = '0;
    m_latch     = '0;
    m_key_en    = 1'b0;
    m_blink     = 1'b0;
    m_ack       = 1'b0;
    m_hold      = 24'd1000;
    m_count     = 0;
  endtask

  function automatic logic m_owner();
    return n < key_until;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    logic lit;
    lit = !m_blink || ((((n - blink_start) / BD) % 2) == 0);
    e.out = m_owner() ? m_latch : (lit ? m_cpu : '0);
    e.ack = m_ack;
    case (s_addr)
      2'd0: e.rd = 32'(m_cpu);
      2'd1: e.rd = {30'd0, m_blink, m_key_en};
      2'd2: e.rd = {16'd0, 8'(m_count), 6'd0, s_req, m_owner()};
      default: e.rd = 32'(m_hold);
    endcase
    return e;
  endfunction

  task automatic model_edge();
    logic wr, clear, acc;
    int   nx;
    nx    = n + 1;
    wr    = s_cs && !s_wn;
    clear = wr && s_addr == 2'd1 && !s_wd[0];
    acc   = m_key_en && s_req && !clear;
    m_ack = acc;
    if (acc) begin
      m_latch   = s_pat;
      key_until = nx + int'(m_hold) + 1;
    end else if (clear && key_until > nx) begin
      key_until = nx;
    end
    if (wr && s_addr == 2'd2)    m_count = 0;
    else if (acc && m_count < 255) m_count++;
    if (wr && s_addr == 2'd0) m_cpu = s_wd[WIDTH-1:0];
    if (wr && s_addr == 2'd3) m_hold = s_wd[23:0];
    if (wr && s_addr == 2'd1) begin
      m_key_en = s_wd[0];
`ifdef LEDR_BLINK_EN
      if (!m_blink && s_wd[1]) blink_start = nx;
      m_blink = s_wd[1];
`endif
    end
  endtask

  // Drive one cycle of stimulus, queue what the DUT must show this cycle, then advance.
  task automatic step();
    bus.address     = s_addr;
    bus.chipselect  = s_cs;
    bus.write_n     = s_wn;
    bus.writedata   = s_wd;
    bus.key_req     = s_req;
    bus.key_pattern = s_pat;
    reset           = s_rst;
    if (s_rst) model_reset();
    sb.push_back(model_expect());
    if (!s_rst) model_edge();
    n++;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    s_addr = a; s_cs = 1'b1; s_wn = 1'b0; s_wd = d;
    step();
    s_cs = 1'b0; s_wn = 1'b1;
  endtask

  task automatic key_pulse(input logic [WIDTH-1:0] p);
    s_req = 1'b1; s_pat = p;
    step();
    s_req = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs, compare against the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_port", 32'(out_port), 32'(e.out));
        check("key_ack",  32'(bus.key_ack), 32'(e.ack));
        check("readdata", bus.readdata, e.rd);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.writedata = '0; bus.key_req = 1'b0; bus.key_pattern = '0;
    model_reset();
    @(posedge clk);
    #1;

    repeat (2) step();
    s_rst = 1'b0;
    step();

    // CPU pattern appears the cycle after the write
    wr(2'd0, 32'h2AAAA);
    s_addr = 2'd2;
    repeat (2) step();

    // Single accept with HOLD=3: four cycles of key display
    wr(2'd3, 32'd3);
    wr(2'd1, 32'd1);
    key_pulse(18'h00F0F);
    s_addr = 2'd2;
    repeat (7) step();

    // Retrigger three cycles into a HOLD=5 display
    wr(2'd3, 32'd5);
    key_pulse(18'h01234);
    repeat (2) step();
    key_pulse(18'h30000);
    repeat (9) step();

    // HOLD=0 gives exactly one cycle
    wr(2'd3, 32'd0);
    key_pulse(18'h15555);
    repeat (3) step();

    // Clearing key_en on the same edge as a request blocks it
    wr(2'd3, 32'd4);
    s_req = 1'b1; s_pat = 18'h0AAAA;
    wr(2'd1, 32'd0);
    repeat (3) step();
    wr(2'd1, 32'd1);
    step();
    s_req = 1'b0;
    repeat (2) step();
    wr(2'd1, 32'd0);
    repeat (3) step();

    // Held request: count saturates, STATUS write clears it
    wr(2'd1, 32'd1);
    s_req = 1'b1; s_pat = 18'h3C3C3;
    s_addr = 2'd2;
    repeat (300) step();
    s_req = 1'b0;
    wr(2'd2, 32'd0);
    s_addr = 2'd2;
    repeat (2) step();

    // HOLD write during a display does not alter the running count
    wr(2'd3, 32'd6);
    key_pulse(18'h00111);
    wr(2'd3, 32'd1);
    repeat (8) step();

    // Reset in the middle of a display
    wr(2'd3, 32'd20);
    key_pulse(18'h2F00F);
    repeat (3) step();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    step();

    // Blink of the CPU pattern; key display stays steady
    wr(2'd0, 32'h3FFFF);
    wr(2'd1, 32'd2);
    s_addr = 2'd1;
    repeat (18) step();
    wr(2'd3, 32'd9);
    wr(2'd1, 32'd3);
    key_pulse(18'h00F0F);
    repeat (14) step();
    wr(2'd1, 32'd1);
    repeat (3) step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_addr = 2'($urandom_range(0, 3));
      s_cs   = ($urandom_range(0, 3) != 0);
      s_wn   = ($urandom_range(0, 7) != 0);
      s_pat  = WIDTH'($urandom);
      s_req  = ($urandom_range(0, 2) == 0);
      case (s_addr)
        2'd1:    s_wd = {$urandom_range(0, 1) == 0 ? 30'd0 : 30'($urandom),
                         1'($urandom), ($urandom_range(0, 7) != 0)};
        2'd3:    s_wd = 32'($urandom_range(0, 6)) | ($urandom_range(0, 1) == 0 ? 32'h0 : 32'hFF00_0000);
        default: s_wd = $urandom;
      endcase
      if ($urandom_range(0, 999) == 0) s_rst = 1'b1;
      step();
      s_rst = 1'b0;
    end

    s_cs = 1'b0; s_wn = 1'b1; s_req = 1'b0;
    step();
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
